// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: opcodes, mux source codes, FSM states.
package pc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BEQ  = 2'b01;
  localparam logic [1:0] SRC_BSUB = 2'b10;

  typedef enum logic {
    StRun,
    StPend
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational decode-redirect resolver: picks the highest-priority taken source,
// its target address and the src/jsel mux encoding.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            dec_valid_i,
  input  logic [XLEN-1:0] dec_pc_i,
  input  logic [5:0]      op_i,
  input  logic [5:0]      funct_i,
  input  logic            eq_i,
  input  logic [15:0]     br_off_i,
  input  logic [25:0]     jidx_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic            b_sub_i,
  input  logic [XLEN-1:0] b_sub_tgt_i,
  output logic            redir_o,
  output logic [XLEN-1:0] tgt_o,
  output logic [1:0]      src_o,
  output logic            jsel_o
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;

  always_comb begin
    pc_plus4 = dec_pc_i + XLEN'(4);
    br_tgt   = pc_plus4 + {{(XLEN-18){br_off_i[15]}}, br_off_i, 2'b00};
    j_tgt    = {pc_plus4[XLEN-1:28], jidx_i, 2'b00};
  end

  // A not-taken beq is not a source at all, so lower-priority sources may still apply.
  always_comb begin
    redir_o = 1'b0;
    tgt_o   = '0;
    src_o   = SRC_SEQ;
    jsel_o  = 1'b0;
    if (dec_valid_i) begin
      if (op_i == OP_BEQ && eq_i) begin
        redir_o = 1'b1;
        tgt_o   = br_tgt;
        src_o   = SRC_BEQ;
      end else if (op_i == OP_J || op_i == OP_JAL) begin
        redir_o = 1'b1;
        tgt_o   = j_tgt;
        jsel_o  = 1'b1;
      end else if (op_i == OP_RTYPE && funct_i == FN_JR) begin
        redir_o = 1'b1;
        tgt_o   = rs_val_i;
        jsel_o  = 1'b1;
      end else if (b_sub_i) begin
        redir_o = 1'b1;
        tgt_o   = b_sub_tgt_i;
        src_o   = SRC_BSUB;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC register, defers exceptions that hit during a stall,
// and counts applied redirects.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] EXC_VEC    = 'h80,
  parameter bit              DELAY_SLOT = 1'b0,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             dec_valid_i,
  input  logic [XLEN-1:0]  dec_pc_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             eq_i,
  input  logic [15:0]      br_off_i,
  input  logic [25:0]      jidx_i,
  input  logic [XLEN-1:0]  rs_val_i,
  input  logic             b_sub_i,
  input  logic [XLEN-1:0]  b_sub_tgt_i,
  input  logic             exc_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [1:0]       src_o,
  output logic             jsel_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            cnt_inc;

  logic            redir;
  logic [XLEN-1:0] tgt;
  logic [1:0]      raw_src;
  logic            raw_jsel;

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_target_calc (
    .dec_valid_i(dec_valid_i),
    .dec_pc_i   (dec_pc_i),
    .op_i       (op_i),
    .funct_i    (funct_i),
    .eq_i       (eq_i),
    .br_off_i   (br_off_i),
    .jidx_i     (jidx_i),
    .rs_val_i   (rs_val_i),
    .b_sub_i    (b_sub_i),
    .b_sub_tgt_i(b_sub_tgt_i),
    .redir_o    (redir),
    .tgt_o      (tgt),
    .src_o      (raw_src),
    .jsel_o     (raw_jsel)
  );

  always_comb begin
    src_o  = exc_i ? SRC_SEQ : raw_src;
    jsel_o = exc_i ? 1'b0 : raw_jsel;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    cnt_inc    = 1'b0;
    flush_o    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (exc_i) begin
          if (stall_i) begin
            pend_tgt_d = EXC_VEC;
            state_d    = StPend;
          end else begin
            pc_d    = EXC_VEC;
            flush_o = 1'b1;
            cnt_inc = 1'b1;
          end
        end else if (!stall_i) begin
          if (redir) begin
            pc_d    = tgt;
            cnt_inc = 1'b1;
            flush_o = !DELAY_SLOT;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      StPend: begin
        if (exc_i) pend_tgt_d = EXC_VEC;
        // Decode redirects in this cycle are dropped; the deferred exception wins.
        if (!stall_i) begin
          pc_d    = pend_tgt_q;
          flush_o = 1'b1;
          cnt_inc = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    cnt_d = (cnt_inc && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign redir_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (no delay slot / wide counter, delay slot / 2-bit counter)
// checked against a queue-free behavioural model plus a directed vector table.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, dv, eq, b_sub, exc;
  logic [5:0]  op, funct;
  logic [31:0] dec_pc, rs_val, b_sub_tgt;
  logic [15:0] br_off;
  logic [25:0] jidx;

  logic [31:0] pc_a, pc_b;
  logic [1:0]  src_a, src_b;
  logic        jsel_a, jsel_b, flush_a, flush_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .dec_valid_i(dv), .dec_pc_i(dec_pc),
    .op_i(op), .funct_i(funct), .eq_i(eq), .br_off_i(br_off), .jidx_i(jidx),
    .rs_val_i(rs_val), .b_sub_i(b_sub), .b_sub_tgt_i(b_sub_tgt), .exc_i(exc),
    .pc_o(pc_a), .src_o(src_a), .jsel_o(jsel_a), .flush_o(flush_a), .redir_cnt_o(cnt_a)
  );

  pc_sequencer #(
    .XLEN(32), .RESET_PC(32'h0), .EXC_VEC(32'h80), .DELAY_SLOT(1'b1), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .dec_valid_i(dv), .dec_pc_i(dec_pc),
    .op_i(op), .funct_i(funct), .eq_i(eq), .br_off_i(br_off), .jidx_i(jidx),
    .rs_val_i(rs_val), .b_sub_i(b_sub), .b_sub_tgt_i(b_sub_tgt), .exc_i(exc),
    .pc_o(pc_b), .src_o(src_b), .jsel_o(jsel_b), .flush_o(flush_b), .redir_cnt_o(cnt_b)
  );

  // Behavioural model, one slot per instance.
  logic [31:0] m_pc[2];
  bit          m_pend[2];
  int          m_cnt[2];
  int          m_cap[2] = '{65535, 3};
  bit          m_ds[2]  = '{1'b0, 1'b1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void dec_eval(output bit redir, output logic [31:0] tgt,
                                   output logic [1:0] src, output bit js);
    longint sx;
    redir = 1'b0; tgt = '0; src = 2'd0; js = 1'b0;
    sx = longint'($signed(br_off));
    if (dv) begin
      if (op == 6'd4 && eq) begin
        redir = 1'b1; src = 2'd1;
        tgt = 32'(longint'(dec_pc) + 4 + 4 * sx);
      end else if (op == 6'd2 || op == 6'd3) begin
        redir = 1'b1; js = 1'b1;
        tgt = ((dec_pc + 32'd4) & 32'hF000_0000) | (32'(jidx) * 4);
      end else if (op == 6'd0 && funct == 6'd8) begin
        redir = 1'b1; js = 1'b1; tgt = rs_val;
      end else if (b_sub) begin
        redir = 1'b1; src = 2'd2; tgt = b_sub_tgt;
      end
    end
    if (exc) begin
      src = 2'd0; js = 1'b0;
    end
  endfunction

  function automatic bit model_flush(input int i, input bit redir);
    if (m_pend[i] || exc) return !stall;
    if (redir && !stall) return !m_ds[i];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'h0; m_pend[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic check_now();
    bit redir, js;
    logic [31:0] tgt;
    logic [1:0] src;
    dec_eval(redir, tgt, src, js);
    chk("pc_a", 64'(pc_a), 64'(m_pc[0]));
    chk("pc_b", 64'(pc_b), 64'(m_pc[1]));
    chk("cnt_a", 64'(cnt_a), 64'(m_cnt[0]));
    chk("cnt_b", 64'(cnt_b), 64'(m_cnt[1]));
    chk("flush_a", 64'(flush_a), 64'(model_flush(0, redir)));
    chk("flush_b", 64'(flush_b), 64'(model_flush(1, redir)));
    chk("src_a", 64'(src_a), 64'(src));
    chk("jsel_a", 64'(jsel_a), 64'(js));
    chk("src_b", 64'(src_b), 64'(src));
    chk("jsel_b", 64'(jsel_b), 64'(js));
  endtask

  task automatic model_update();
    bit redir, js, inc;
    logic [31:0] tgt;
    logic [1:0] src;
    dec_eval(redir, tgt, src, js);
    for (int i = 0; i < 2; i++) begin
      inc = 1'b0;
      if (m_pend[i]) begin
        if (!stall) begin m_pc[i] = 32'h80; m_pend[i] = 1'b0; inc = 1'b1; end
      end else if (exc) begin
        if (stall) m_pend[i] = 1'b1;
        else begin m_pc[i] = 32'h80; inc = 1'b1; end
      end else if (!stall) begin
        if (redir) begin m_pc[i] = tgt; inc = 1'b1; end
        else m_pc[i] = m_pc[i] + 32'd4;
      end
      if (inc && m_cnt[i] < m_cap[i]) m_cnt[i]++;
    end
  endtask

  // Entered at posedge+1: check mid-cycle, cross the edge, advance the model.
  task automatic step();
    #3;
    check_now();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_inputs();
    stall = 0; dv = 0; eq = 0; b_sub = 0; exc = 0; op = 0; funct = 0;
    dec_pc = 0; rs_val = 0; b_sub_tgt = 0; br_off = 0; jidx = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pc_a", 64'(pc_a), 64'h0);
    chk("rst_cnt_a", 64'(cnt_a), 64'h0);
    chk("rst_flush_a", 64'(flush_a), 64'h0);
    chk("rst_src_a", 64'(src_a), 64'h0);
    chk("rst_jsel_a", 64'(jsel_a), 64'h0);
    chk("rst_pc_b", 64'(pc_b), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          stall, dv, exc;
    logic [5:0]  op, funct;
    bit          eq, b_sub;
    logic [31:0] dec_pc;
    logic [15:0] off;
    logic [25:0] jidx;
    logic [31:0] aux;
    logic [1:0]  e_src;
    bit          e_jsel, e_flush;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  function automatic vec_t v(bit s, bit d, bit x, logic [5:0] o, logic [5:0] f, bit q, bit bs,
                             logic [31:0] p, logic [15:0] off, logic [25:0] ji, logic [31:0] aux,
                             logic [1:0] es, bit ej, bit ef, logic [31:0] epc, int ec);
    vec_t r;
    r.stall = s; r.dv = d; r.exc = x; r.op = o; r.funct = f; r.eq = q; r.b_sub = bs;
    r.dec_pc = p; r.off = off; r.jidx = ji; r.aux = aux;
    r.e_src = es; r.e_jsel = ej; r.e_flush = ef; r.e_pc = epc; r.e_cnt = ec;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // stall dv exc op funct eq bsub dec_pc off jidx aux | src jsel flush next_pc cnt
    tbl.push_back(v(0,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'h4,0));
    tbl.push_back(v(0,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'h8,0));
    tbl.push_back(v(0,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'hC,0));
    tbl.push_back(v(0,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'h10,0));
    tbl.push_back(v(0,1,0,4,0,1,0,32'h100,16'h3,26'h0,32'h0,          1,0,1,32'h110,1));
    tbl.push_back(v(0,1,0,4,0,0,0,32'h100,16'h3,26'h0,32'h0,          0,0,0,32'h114,1));
    tbl.push_back(v(0,1,0,2,0,0,0,32'h1000_0040,16'h0,26'h10,32'h0,   0,1,1,32'h1000_0040,2));
    tbl.push_back(v(0,1,0,0,8,0,0,32'h0,16'h0,26'h0,32'h2000,         0,1,1,32'h2000,3));
    tbl.push_back(v(1,1,1,4,0,1,0,32'h100,16'h3,26'h0,32'h0,          0,0,0,32'h2000,3));
    tbl.push_back(v(1,1,0,4,0,1,0,32'h100,16'h3,26'h0,32'h0,          1,0,0,32'h2000,3));
    tbl.push_back(v(1,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'h2000,3));
    tbl.push_back(v(0,1,0,4,0,1,0,32'h100,16'h3,26'h0,32'h0,          1,0,1,32'h80,4));
    tbl.push_back(v(0,1,1,0,0,0,1,32'h0,16'h0,26'h0,32'h4000,         0,0,1,32'h80,5));
    tbl.push_back(v(0,1,0,0,0,0,1,32'h0,16'h0,26'h0,32'h4000,         2,0,1,32'h4000,6));
    tbl.push_back(v(0,1,0,4,0,1,0,32'h200,16'hFFFF,26'h0,32'h0,       1,0,1,32'h200,7));
    tbl.push_back(v(0,0,0,2,0,0,0,32'h200,16'h0,26'h10,32'h0,         0,0,0,32'h204,7));
    tbl.push_back(v(1,1,0,2,0,0,0,32'h200,16'h0,26'h10,32'h0,         0,1,0,32'h204,7));
    tbl.push_back(v(0,1,0,3,0,0,0,32'hF000_0000,16'h0,26'h3FF_FFFF,32'h0, 0,1,1,32'hFFFF_FFFC,8));
    tbl.push_back(v(0,0,0,0,0,0,0,32'h0,16'h0,26'h0,32'h0,            0,0,0,32'h0,8));

    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[k]) begin
      stall = tbl[k].stall; dv = tbl[k].dv; exc = tbl[k].exc; op = tbl[k].op;
      funct = tbl[k].funct; eq = tbl[k].eq; b_sub = tbl[k].b_sub; dec_pc = tbl[k].dec_pc;
      br_off = tbl[k].off; jidx = tbl[k].jidx; rs_val = tbl[k].aux; b_sub_tgt = tbl[k].aux;
      #3;
      chk($sformatf("vec%0d_src", k), 64'(src_a), 64'(tbl[k].e_src));
      chk($sformatf("vec%0d_jsel", k), 64'(jsel_a), 64'(tbl[k].e_jsel));
      chk($sformatf("vec%0d_flush", k), 64'(flush_a), 64'(tbl[k].e_flush));
      check_now();
      @(posedge clk);
      #1;
      model_update();
      chk($sformatf("vec%0d_pc", k), 64'(pc_a), 64'(tbl[k].e_pc));
      chk($sformatf("vec%0d_cnt", k), 64'(cnt_a), 64'(tbl[k].e_cnt));
    end

    // Saturating counter and delay-slot flush behaviour.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      dv = 1; op = 6'd2; jidx = 26'(k + 1); dec_pc = 32'h0;
      #3;
      chk("ds_jump_flush_b", 64'(flush_b), 64'h0);
      chk("ds_jump_flush_a", 64'(flush_a), 64'h1);
      check_now();
      @(posedge clk);
      #1;
      model_update();
    end
    chk("sat_cnt_b", 64'(cnt_b), 64'h3);
    chk("sat_cnt_a", 64'(cnt_a), 64'h5);
    idle_inputs();
    exc = 1;
    #3;
    chk("ds_exc_flush_b", 64'(flush_b), 64'h1);
    check_now();
    @(posedge clk);
    #1;
    model_update();
    chk("exc_pc_b", 64'(pc_b), 64'h80);

    // Async reset while an exception is pending must drop it.
    idle_inputs();
    stall = 1; exc = 1;
    step();
    exc = 0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midpend_rst_pc_a", 64'(pc_a), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_update();
    stall = 0;
    step();
    step();
    chk("midpend_pc_a", 64'(pc_a), 64'h8);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      dv    = ($urandom_range(0, 4) != 0);
      exc   = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: op = 6'd0;
        1: op = 6'd2;
        2: op = 6'd3;
        3: op = 6'd4;
        default: op = 6'($urandom);
      endcase
      funct     = ($urandom_range(0, 1) == 0) ? 6'd8 : 6'($urandom);
      eq        = 1'($urandom);
      b_sub     = 1'($urandom);
      if (op == 6'd4 && !eq) b_sub = 1'b0;
      dec_pc    = $urandom;
      rs_val    = $urandom;
      b_sub_tgt = $urandom;
      br_off    = 16'($urandom);
      jidx      = 26'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
